// File: rtl/e203_gpio_pad_bank_if.sv
// Signal bundle between the SoC GPIO block / bank configuration and one
// e203_gpio_pad_bank instance.
interface e203_gpio_pad_bank_if #(
    parameter int GPIO_W = 32,
    parameter int DEB_W  = 16
);
    logic [GPIO_W-1:0] core_o_oval;
    logic [GPIO_W-1:0] core_o_oe;
    logic [GPIO_W-1:0] pad_i;
    logic [GPIO_W-1:0] pad_o;
    logic [GPIO_W-1:0] pad_t;
    logic [GPIO_W-1:0] in_sync;
    logic [GPIO_W-1:0] in_deb;
    logic [GPIO_W-1:0] deb_en;
    logic [DEB_W-1:0]  deb_limit;
    logic [GPIO_W-1:0] rise_en;
    logic [GPIO_W-1:0] fall_en;
    logic [GPIO_W-1:0] irq_clr;
    logic [GPIO_W-1:0] irq_pending;
    logic              irq;

    modport master (
        output core_o_oval, core_o_oe, pad_i, deb_en, deb_limit,
               rise_en, fall_en, irq_clr,
        input  pad_o, pad_t, in_sync, in_deb, irq_pending, irq
    );

    modport slave (
        input  core_o_oval, core_o_oe, pad_i, deb_en, deb_limit,
               rise_en, fall_en, irq_clr,
        output pad_o, pad_t, in_sync, in_deb, irq_pending, irq
    );
endinterface

// File: rtl/e203_gpio_pad_bank.sv
// GPIO pad-side bank: registered output/tristate drive, input synchroniser,
// per-bit debounce, edge detection with sticky pending bits and an interrupt.
module e203_gpio_pad_bank #(
    parameter int GPIO_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    e203_gpio_pad_bank_if.slave  bus
);

    logic [GPIO_W-1:0] pad_o_q;
    logic [GPIO_W-1:0] pad_t_q;
    logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_W-1:0] in_sync;
    logic [GPIO_W-1:0] deb_q;
    logic [GPIO_W-1:0] deb_nxt;
    logic [DEB_W-1:0]  cnt_q [GPIO_W];
    logic [DEB_W-1:0]  cnt_d [GPIO_W];
    logic [GPIO_W-1:0] deb_hist;
    logic [GPIO_W-1:0] rise;
    logic [GPIO_W-1:0] fall;
    logic [GPIO_W-1:0] pend_q;
    logic [GPIO_W-1:0] pend_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pad_o_q <= '0;
            pad_t_q <= '1;
        end else begin
            pad_o_q <= bus.core_o_oval;
            pad_t_q <= ~bus.core_o_oe;
        end
    end

    // pad_i is asynchronous; only the last stage is used downstream
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= bus.pad_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];

    // A differing level must persist past deb_limit counted cycles before
    // in_deb follows; the counter saturates rather than wrapping.
    always_comb begin
        deb_nxt = deb_q;
        for (int i = 0; i < GPIO_W; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!bus.deb_en[i]) begin
                deb_nxt[i] = in_sync[i];
                cnt_d[i]   = '0;
            end else if (in_sync[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= bus.deb_limit) begin
                deb_nxt[i] = in_sync[i];
                cnt_d[i]   = '0;
            end else if (cnt_q[i] != {DEB_W{1'b1}}) begin
                cnt_d[i] = cnt_q[i] + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_q <= '0;
            for (int i = 0; i < GPIO_W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_nxt;
            for (int i = 0; i < GPIO_W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rise = deb_q & ~deb_hist;
    assign fall = ~deb_q & deb_hist;

    // Setting dominates clearing when both happen in the same cycle
    always_comb begin
        pend_nxt = (pend_q & ~bus.irq_clr)
                 | (rise & bus.rise_en)
                 | (fall & bus.fall_en);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_hist <= '0;
            pend_q   <= '0;
        end else begin
            deb_hist <= deb_q;
            pend_q   <= pend_nxt;
        end
    end

    assign bus.pad_o       = pad_o_q;
    assign bus.pad_t       = pad_t_q;
    assign bus.in_sync     = in_sync;
    assign bus.in_deb      = deb_q;
    assign bus.irq_pending = pend_q;
    assign bus.irq         = |pend_q;

endmodule

// File: tb/tb_e203_gpio_pad_bank.sv
// Directed bench for e203_gpio_pad_bank with hand-computed expectations,
// checked by immediate assertions at each step.
module tb_e203_gpio_pad_bank;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    e203_gpio_pad_bank_if #(.GPIO_W(32), .DEB_W(16)) bus ();

    e203_gpio_pad_bank #(
        .GPIO_W(32),
        .SYNC_STAGES(2),
        .DEB_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.core_o_oval = 32'h0000_00A5;
        bus.core_o_oe   = 32'h0000_00FF;
        bus.pad_i       = '0;
        bus.deb_en      = '0;
        bus.deb_limit   = '0;
        bus.rise_en     = '0;
        bus.fall_en     = '0;
        bus.irq_clr     = '0;

        // Reset and output path
        step(3);
        check("rst_pad_t", bus.pad_t, 32'hFFFF_FFFF);
        check("rst_pad_o", bus.pad_o, 32'h0);
        check("rst_in_sync", bus.in_sync, 32'h0);
        check("rst_in_deb", bus.in_deb, 32'h0);
        check("rst_pending", bus.irq_pending, 32'h0);
        check("rst_irq", {31'b0, bus.irq}, 32'h0);
        rst_n = 1'b1;
        step(1);
        check("out_pad_t", bus.pad_t, 32'hFFFF_FF00);
        check("out_pad_o", bus.pad_o, 32'h0000_00A5);
        bus.core_o_oval = 32'h0000_005A;
        bus.core_o_oe   = 32'h0000_000F;
        #1;
        check("out_no_comb", bus.pad_o, 32'h0000_00A5);
        step(1);
        check("out_pad_o2", bus.pad_o, 32'h0000_005A);
        check("out_pad_t2", bus.pad_t, 32'hFFFF_FFF0);

        // Bypass latency on bit 0
        bus.rise_en = 32'h1;
        bus.pad_i   = 32'h1;
        step(1);
        check("byp_sync_c1", bus.in_sync, 32'h0);
        step(1);
        check("byp_sync_c2", bus.in_sync, 32'h1);
        check("byp_deb_c2", bus.in_deb, 32'h0);
        step(1);
        check("byp_deb_c3", bus.in_deb, 32'h1);
        check("byp_pend_c3", bus.irq_pending, 32'h0);
        step(1);
        check("byp_pend_c4", bus.irq_pending, 32'h1);
        check("byp_irq_c4", {31'b0, bus.irq}, 32'h1);
        bus.rise_en = '0;
        bus.irq_clr = 32'h1;
        step(1);
        bus.irq_clr = '0;
        check("byp_clr", bus.irq_pending, 32'h0);

        // Glitch rejection on bit 3 with limit 4
        bus.deb_en    = 32'h8;
        bus.deb_limit = 16'd4;
        bus.pad_i     = 32'h9;
        step(4);
        bus.pad_i     = 32'h1;
        step(10);
        check("glitch_reject", {31'b0, bus.in_deb[3]}, 32'h0);
        bus.pad_i = 32'h9;
        step(2);
        check("stable_sync", {31'b0, bus.in_sync[3]}, 32'h1);
        check("stable_deb_0", {31'b0, bus.in_deb[3]}, 32'h0);
        step(4);
        check("stable_deb_4", {31'b0, bus.in_deb[3]}, 32'h0);
        step(1);
        check("stable_deb_5", {31'b0, bus.in_deb[3]}, 32'h1);

        // Fall edge, enable gating and write-1-to-clear on bit 7
        bus.fall_en = 32'h80;
        bus.pad_i   = 32'h89;
        step(4);
        check("fall_pre", bus.irq_pending, 32'h0);
        bus.pad_i = 32'h09;
        step(4);
        check("fall_pend", bus.irq_pending, 32'h80);
        check("fall_irq", {31'b0, bus.irq}, 32'h1);
        bus.fall_en = '0;
        step(1);
        check("fall_en_off_keeps", bus.irq_pending, 32'h80);
        bus.fall_en = 32'h80;
        bus.pad_i   = 32'h89;
        step(4);
        bus.pad_i = 32'h09;
        step(3);
        bus.irq_clr = 32'h80;
        step(1);
        bus.irq_clr = '0;
        check("set_beats_clr", bus.irq_pending, 32'h80);
        bus.irq_clr = 32'h80;
        step(1);
        bus.irq_clr = '0;
        check("w1c_pend", bus.irq_pending, 32'h0);
        check("w1c_irq", {31'b0, bus.irq}, 32'h0);

        // Disabled edges, all bits toggling in bypass
        bus.fall_en = '0;
        bus.deb_en  = '0;
        bus.pad_i   = 32'hFFFF_FFFF;
        step(3);
        check("dis_deb_ff", bus.in_deb, 32'hFFFF_FFFF);
        bus.pad_i = 32'h5A5A_5A5A;
        step(3);
        check("dis_deb_5a", bus.in_deb, 32'h5A5A_5A5A);
        bus.pad_i = 32'h0;
        step(3);
        check("dis_deb_00", bus.in_deb, 32'h0);
        step(1);
        check("dis_pend", bus.irq_pending, 32'h0);
        check("dis_irq", {31'b0, bus.irq}, 32'h0);

        // Reset with pending bits and a debounce count in flight
        bus.rise_en   = 32'h111;
        bus.deb_en    = 32'h100;
        bus.deb_limit = 16'd4;
        bus.pad_i     = 32'h111;
        step(5);
        check("pre_rst_pend", bus.irq_pending, 32'h11);
        check("pre_rst_deb", bus.in_deb, 32'h11);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("mid_rst_pend", bus.irq_pending, 32'h0);
        check("mid_rst_irq", {31'b0, bus.irq}, 32'h0);
        check("mid_rst_deb", bus.in_deb, 32'h0);
        check("mid_rst_pad_t", bus.pad_t, 32'hFFFF_FFFF);
        step(3);
        check("exit_deb_r3", bus.in_deb, 32'h11);
        check("exit_pend_r3", bus.irq_pending, 32'h0);
        step(1);
        check("exit_pend_r4", bus.irq_pending, 32'h11);
        step(2);
        check("exit_deb_r6", bus.in_deb, 32'h11);
        step(1);
        check("exit_deb_r7", bus.in_deb, 32'h111);
        step(1);
        check("exit_pend_r8", bus.irq_pending, 32'h111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
